// File: rtl/win_tx_pkg.sv
// Shared types and link-word constants for the windowed-averager sample transmitter.
package win_tx_pkg;

  typedef struct packed {
    logic [1:0] t;
    logic [1:0] y;
    logic [1:0] x;
  } sample_t;

  localparam logic [1:0] P_SAMPLE  = 2'b11;
  localparam logic [1:0] P_CSUM    = 2'b10;
  localparam logic [7:0] IDLE_WORD = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } tx_state_e;

  function automatic logic [7:0] make_word(input logic [1:0] p, input sample_t s);
    return {p, s};
  endfunction

endpackage

// File: rtl/win_tx_fifo.sv
// DEPTH-entry synchronous sample FIFO: registered storage, combinational head read,
// flush has priority over push/pop.
module win_tx_fifo
  import win_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  sample_t                wr_data,
  output sample_t                rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sample_t         mem_q [DEPTH];
  sample_t         mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok_s, pop_ok_s;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/window_sample_tx.sv
// Paced link-word transmitter for the windowed averager: FIFO, IDLE/GAP pacer, output
// register. Optional group checksum words are enabled by defining WIN_TX_CHECKSUM_EN.
module window_sample_tx
  import win_tx_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PACE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_x,
  input  logic [1:0]             in_y,
  input  logic [1:0]             in_t,
  input  logic [PACE_W-1:0]      pace,
  input  logic                   flush,
  output logic [7:0]             out_word,
  output logic                   out_fire,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  tx_state_e          state_q, state_d;
  logic [PACE_W-1:0]  gap_q, gap_d;
  logic [7:0]         word_q, word_d;
  logic               fire_q, fire_d;

  logic [CW-1:0]      count_s;
  logic               empty_s, full_s;
  logic               push_s, pop_s;
  logic               csum_due_s, csum_emit_s;
  logic [7:0]         csum_word_s;
  sample_t            head_s, in_sample_s;

  assign in_sample_s = '{t: in_t, y: in_y, x: in_x};
  assign in_ready    = (count_s < DEPTH_C);
  assign push_s      = in_valid && in_ready;
  assign fifo_count  = count_s;
  assign out_word    = word_q;
  assign out_fire    = fire_q;

  win_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (in_sample_s),
    .rd_data (head_s),
    .count   (count_s),
    .empty   (empty_s),
    .full    (full_s)
  );

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    word_d      = IDLE_WORD;
    fire_d      = 1'b0;
    pop_s       = 1'b0;
    csum_emit_s = 1'b0;
    if (flush) begin
      state_d = IDLE;
      gap_d   = {PACE_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          // A slot is open; a due checksum wins over the FIFO head.
          if ((gap_q == {PACE_W{1'b0}}) && (csum_due_s || !empty_s)) begin
            fire_d  = 1'b1;
            gap_d   = pace;
            state_d = (pace != {PACE_W{1'b0}}) ? GAP : IDLE;
            if (csum_due_s) begin
              word_d      = csum_word_s;
              csum_emit_s = 1'b1;
            end else begin
              word_d = make_word(P_SAMPLE, head_s);
              pop_s  = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        GAP: begin
          if (gap_q <= {{(PACE_W-1){1'b0}}, 1'b1}) begin
            gap_d   = {PACE_W{1'b0}};
            state_d = IDLE;
          end else begin
            gap_d   = gap_q - {{(PACE_W-1){1'b0}}, 1'b1};
            state_d = GAP;
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = {PACE_W{1'b0}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      gap_q   <= {PACE_W{1'b0}};
      word_q  <= IDLE_WORD;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      fire_q  <= fire_d;
    end
  end

`ifdef WIN_TX_CHECKSUM_EN
  sample_t        sum_q, sum_d;
  logic [CW-1:0]  grp_q, grp_d;

  assign csum_due_s  = (grp_q == DEPTH_C);
  assign csum_word_s = make_word(P_CSUM, sum_q);

  // Sums are 2-bit fields, so additions wrap mod 4 on their own.
  always_comb begin
    sum_d = sum_q;
    grp_d = grp_q;
    if (flush || csum_emit_s) begin
      sum_d = '0;
      grp_d = {CW{1'b0}};
    end else if (pop_s) begin
      sum_d.x = sum_q.x + head_s.x;
      sum_d.y = sum_q.y + head_s.y;
      sum_d.t = sum_q.t + head_s.t;
      grp_d   = grp_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      sum_d = sum_q;
      grp_d = grp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sum_q <= '0;
      grp_q <= {CW{1'b0}};
    end else begin
      sum_q <= sum_d;
      grp_q <= grp_d;
    end
  end
`else
  assign csum_due_s  = 1'b0;
  assign csum_word_s = IDLE_WORD;
`endif

endmodule

// File: tb/tb_window_sample_tx.sv
// Self-checking bench for window_sample_tx: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed link words.
module tb_window_sample_tx;

  localparam int DEPTH  = 4;
  localparam int PACE_W = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_x, in_y, in_t;
  logic [3:0]  pace;
  logic        flush;
  logic [7:0]  out_word;
  logic        out_fire;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  window_sample_tx #(.DEPTH(DEPTH), .PACE_W(PACE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_t       (in_t),
    .pace       (pace),
    .flush      (flush),
    .out_word   (out_word),
    .out_fire   (out_fire),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [5:0] mq[$];
  int         cyc = 0;
  int         next_slot = 0;
  int         grp = 0;
  int         sx = 0, sy = 0, st = 0;
  bit         model_valid = 1'b0;
  logic [7:0] e_word;
  logic       e_fire;
  int         e_count;

`ifdef WIN_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  task automatic model_clear();
    mq.delete();
    next_slot = cyc + 1;
    grp = 0; sx = 0; sy = 0; st = 0;
    e_word = 8'h00;
    e_fire = 1'b0;
  endtask

  // Predicts the outputs after the coming posedge from the inputs now on the pins.
  task automatic model_step();
    logic [5:0] s;
    bit         acc;
    bit         due;
    cyc++;
    if (rst_n) begin
      model_clear();
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (flush) begin
        model_clear();
      end else begin
        acc    = in_valid && (mq.size() < DEPTH);
        due    = CSUM_EN && (grp == DEPTH);
        e_word = 8'h00;
        e_fire = 1'b0;
        if (cyc >= next_slot && (due || mq.size() > 0)) begin
          if (due) begin
            e_word = {2'b10, 2'(st), 2'(sy), 2'(sx)};
            grp = 0; sx = 0; sy = 0; st = 0;
          end else begin
            s      = mq.pop_front();
            e_word = {2'b11, s};
            sx += int'(s[1:0]); sy += int'(s[3:2]); st += int'(s[5:4]);
            grp++;
          end
          e_fire    = 1'b1;
          next_slot = cyc + int'(pace) + 1;
        end
        if (acc) mq.push_back({in_t, in_y, in_x});
      end
    end
    e_count = mq.size();
  endtask

  // Compare process: check last edge's prediction, then predict the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("word",  32'(out_word),   32'(e_word));
        check("fire",  32'(out_fire),   32'(e_fire));
        check("count", 32'(fifo_count), 32'(e_count));
        check("ready", 32'(in_ready),   32'(e_count < DEPTH));
      end
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic set_sample(input int x, input int y, input int t);
    in_x = 2'(x); in_y = 2'(y); in_t = 2'(t);
  endtask

  int         nf, peak, n_acc, fires;
  int         fire_c[3];
  logic [7:0] fire_w[3];
  int         acc_edge[6];
  logic [7:0] words[$];
  bit         acc;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; pace = 4'd0;
    set_sample(0, 0, 0);

    // 1: reset values, single sample back-to-back pacing
    do_reset();
    check("rst_word",  32'(out_word),   32'h00);
    check("rst_fire",  32'(out_fire),   32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_ready", 32'(in_ready),   32'h1);
    pace = 4'd0; set_sample(1, 2, 3); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t1_word", 32'(out_word), 32'hF9);
    check("t1_fire", 32'(out_fire), 32'h1);
    tick();
    check("t1_idle_word", 32'(out_word), 32'h00);
    check("t1_idle_fire", 32'(out_fire), 32'h0);

    // 2: pace=3, three samples pushed back-to-back
    do_reset();
    pace = 4'd3; nf = 0; peak = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 3);
      set_sample(c, 3 - c, 1);
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (out_fire) begin
        if (nf < 3) begin
          fire_c[nf] = c;
          fire_w[nf] = out_word;
        end
        nf++;
      end
    end
    in_valid = 1'b0;
    check("t2_nwords", 32'(nf), 32'd3);
    check("t2_peak",   32'(peak), 32'd2);
    check("t2_c0", 32'(fire_c[0]), 32'd1);
    check("t2_c1", 32'(fire_c[1]), 32'd5);
    check("t2_c2", 32'(fire_c[2]), 32'd9);
    check("t2_w0", 32'(fire_w[0]), 32'hDC);
    check("t2_w1", 32'(fire_w[1]), 32'hD9);
    check("t2_w2", 32'(fire_w[2]), 32'hD6);

    // 3: stalled output fills the FIFO; the 6th push waits for the next pop
    do_reset();
    pace = 4'd15; n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (n_acc < 6);
      set_sample(n_acc, n_acc + 1, n_acc + 2);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        acc_edge[n_acc] = c;
        n_acc++;
        if (n_acc == 5) begin
          check("t3_full_ready", 32'(in_ready),   32'h0);
          check("t3_full_count", 32'(fifo_count), 32'd4);
        end
      end
    end
    in_valid = 1'b0;
    check("t3_naccepted", 32'(n_acc), 32'd6);
    check("t3_6th_edge",  32'(acc_edge[5]), 32'd18);

    // 4: flush with a same-edge push discards everything
    do_reset();
    pace = 4'd15;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; set_sample(c, c, c);
      tick();
    end
    check("t4_buffered", 32'(fifo_count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; set_sample(3, 3, 3);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_count", 32'(fifo_count), 32'd0);
    fires = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (out_fire) fires++;
    end
    check("t4_no_words", 32'(fires), 32'd0);

    // 5: reset in the middle of a gap
    do_reset();
    pace = 4'd5; set_sample(2, 2, 2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("t5_word",  32'(out_word),   32'h00);
    check("t5_fire",  32'(out_fire),   32'h0);
    check("t5_count", 32'(fifo_count), 32'h0);
    pace = 4'd0; set_sample(1, 2, 3); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_word_after", 32'(out_word), 32'hF9);

`ifdef WIN_TX_CHECKSUM_EN
    // 6: checksum word after every DEPTH samples, sums restart per group
    do_reset();
    pace = 4'd0; words.delete();
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 4) || (c >= 10 && c < 14);
      if (c < 4) set_sample((c == 0) ? 1 : (c == 1) ? 2 : 3, 0, 0);
      else set_sample(1, 0, 0);
      tick();
      if (out_fire) words.push_back(out_word);
    end
    in_valid = 1'b0;
    check("t6_nwords", 32'(words.size()), 32'd10);
    if (words.size() == 10) begin
      check("t6_first", 32'(words[0]), 32'hC1);
      check("t6_csum1", 32'(words[4]), 32'h81);
      check("t6_csum2", 32'(words[9]), 32'h80);
    end
`endif

    // Randomized traffic with occasional flush and reset, checked by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_x = 2'($urandom); in_y = 2'($urandom); in_t = 2'($urandom);
      pace = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      tick();
    end
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 40; c++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
